// File: rtl/piso_serializer_pkg.sv
// Shared constants for the parallel-in serial-out serializer: FSM state encodings,
// the serial line idle level and a counter-width helper.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

  // Width needed to hold 0..n-1, never less than one bit so n=1 stays legal.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 and wraps, tick is high during count DIV-1.
// Held at zero while clr or R is asserted, so the first period after clear is a full DIV cycles.
module bit_timer
  import piso_serializer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic C,
  input  logic R,
  input  logic clr,
  output logic tick
);

  localparam int CW = width_of(DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge C) begin
    if (R || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// UART-style serializer: start bit 0, WIDTH data bits LSB first, stop bit 1, DIV cycles per bit.
// Q is registered; Rdy is high only in IDLE, and a word offered while busy is ignored.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             V,
  output logic             Rdy,
  output logic             Q,
  output logic             Busy
);

  localparam int IW = width_of(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             q_q, q_d;
  logic             clr;
  logic             tick;

  bit_timer #(.DIV(DIV)) u_timer (
    .C    (C),
    .R    (R),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      q_q     <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
    end
  end

  // Q is computed one cycle ahead so the registered line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    q_d     = q_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        clr = 1'b1;
        q_d = LINE_IDLE;
        if (V) begin
          sh_d    = D;
          idx_d   = '0;
          state_d = START;
          q_d     = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
          q_d     = sh_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == IW'(WIDTH - 1)) begin
            state_d = STOP;
            q_d     = LINE_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
            sh_d  = sh_q >> 1;
            q_d   = sh_d[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          q_d     = LINE_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        q_d     = LINE_IDLE;
      end
    endcase
  end

  assign Q    = q_q;
  assign Rdy  = (state_q == IDLE);
  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: 8-bit/DIV=4 instance for the main scenarios, 1-bit/DIV=1 instance for the minimum corner.
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  logic       C = 1'b0;
  logic       R;
  logic [7:0] D;
  logic       V;
  logic       Rdy, Q, Busy;
  logic       D1;
  logic       V1;
  logic       Rdy1, Q1, Busy1;

  int n_chk  = 0;
  int n_fail = 0;

  piso_serializer #(.WIDTH(8), .DIV(4)) u_dut (
    .C    (C),
    .R    (R),
    .D    (D),
    .V    (V),
    .Rdy  (Rdy),
    .Q    (Q),
    .Busy (Busy)
  );

  piso_serializer #(.WIDTH(1), .DIV(1)) u_dut1 (
    .C    (C),
    .R    (R),
    .D    (D1),
    .V    (V1),
    .Rdy  (Rdy1),
    .Q    (Q1),
    .Busy (Busy1)
  );

  always #5 C = ~C;

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the first cycle after acceptance; returns on the first IDLE cycle.
  task automatic frame(input string nm, input logic [7:0] w);
    logic [9:0] fr;
    fr = {1'b1, w, 1'b0};
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("%s q[%0d]", nm, k), 2'(Q), 2'(fr[k / 4]));
      if (k % 4 == 0) begin
        chk($sformatf("%s rdy[%0d]", nm, k), 2'(Rdy), 2'b00);
        chk($sformatf("%s busy[%0d]", nm, k), 2'(Busy), 2'b01);
      end
      step();
    end
    chk({nm, " end rdy"}, 2'(Rdy), 2'b01);
    chk({nm, " end busy"}, 2'(Busy), 2'b00);
    chk({nm, " end q"}, 2'(Q), 2'b01);
  endtask

  initial begin
    R  = 1'b1;
    D  = 8'h00;
    V  = 1'b0;
    D1 = 1'b0;
    V1 = 1'b0;
    step();
    step();
    chk("rst q", 2'(Q), 2'b01);
    chk("rst rdy", 2'(Rdy), 2'b01);
    chk("rst busy", 2'(Busy), 2'b00);
    chk("rst state", 2'(u_dut.state_q), 2'(IDLE));
    R = 1'b0;
    step();
    chk("idle q", 2'(Q), 2'b01);

    // Scenario 1: basic frame of 8'hA5
    D = 8'hA5;
    V = 1'b1;
    step();
    V = 1'b0;
    D = 8'h00;
    frame("s1", 8'hA5);
    step();

    // Scenario 2: D changes after acceptance
    D = 8'h3C;
    V = 1'b1;
    step();
    V = 1'b0;
    D = 8'hFF;
    frame("s2", 8'h3C);
    step();

    // Scenario 3: V held high, back-to-back frames
    D = 8'h01;
    V = 1'b1;
    step();
    frame("s3a", 8'h01);
    D = 8'h80;
    step();
    V = 1'b0;
    frame("s3b", 8'h80);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("s3 idle q[%0d]", i), 2'(Q), 2'b01);
      chk($sformatf("s3 idle rdy[%0d]", i), 2'(Rdy), 2'b01);
    end

    // Scenario 4: reset during the third data bit of 8'h5A
    D = 8'h5A;
    V = 1'b1;
    step();
    V = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("s4 bit2 q", 2'(Q), 2'b00);
    chk("s4 bit2 busy", 2'(Busy), 2'b01);
    R = 1'b1;
    step();
    R = 1'b0;
    chk("s4 abort q", 2'(Q), 2'b01);
    chk("s4 abort rdy", 2'(Rdy), 2'b01);
    chk("s4 abort busy", 2'(Busy), 2'b00);
    chk("s4 abort state", 2'(u_dut.state_q), 2'(IDLE));
    step();
    chk("s4 after q", 2'(Q), 2'b01);
    chk("s4 after rdy", 2'(Rdy), 2'b01);
    D = 8'h96;
    V = 1'b1;
    step();
    V = 1'b0;
    frame("s4", 8'h96);
    step();

    // Scenario 5: reset and valid on the same edge
    D = 8'h00;
    V = 1'b1;
    R = 1'b1;
    step();
    R = 1'b0;
    V = 1'b0;
    chk("s5 q", 2'(Q), 2'b01);
    chk("s5 rdy", 2'(Rdy), 2'b01);
    step();
    chk("s5 next q", 2'(Q), 2'b01);
    chk("s5 next busy", 2'(Busy), 2'b00);

    // Scenario 6: WIDTH=1, DIV=1, data 1 then data 0
    chk("s6 idle q", 2'(Q1), 2'b01);
    D1 = 1'b1;
    V1 = 1'b1;
    step();
    V1 = 1'b0;
    chk("s6a start q", 2'(Q1), 2'b00);
    chk("s6a start busy", 2'(Busy1), 2'b01);
    step();
    chk("s6a data q", 2'(Q1), 2'b01);
    step();
    chk("s6a stop q", 2'(Q1), 2'b01);
    chk("s6a stop busy", 2'(Busy1), 2'b01);
    step();
    chk("s6a idle rdy", 2'(Rdy1), 2'b01);
    chk("s6a idle busy", 2'(Busy1), 2'b00);
    D1 = 1'b0;
    V1 = 1'b1;
    step();
    V1 = 1'b0;
    chk("s6b start q", 2'(Q1), 2'b00);
    step();
    chk("s6b data q", 2'(Q1), 2'b00);
    step();
    chk("s6b stop q", 2'(Q1), 2'b01);
    step();
    chk("s6b idle rdy", 2'(Rdy1), 2'b01);
    chk("s6b idle q", 2'(Q1), 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
